npu_result_reader: RTL and testbench

- Read-side counterpart to the host-to-NPU memory writer. It accepts the NPU's serial 8-bit result stream, which is the PISO output.
- It packs every four bytes into one 32-bit word and buffers the words in a small FIFO.
- The host drains the FIFO over the same chipselect-qualified Avalon-style slave bus that the writer uses.
- Sits between the NPU output stage and the Avalon bus fabric.

---
 rtl/npu_bus_pkg.sv | 35 +++
 rtl/npu_result_reader_if.sv | 27 ++
 rtl/npu_word_fifo.sv | 57 +++++
 rtl/npu_result_reader.sv | 123 ++++++++++++
 tb/tb_npu_result_reader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_bus_pkg.sv
// Bus map, status layout and byte-lane order shared by the NPU host writer and result reader.
package npu_bus_pkg;

  localparam logic [1:0] ADDR_POP    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_CLEAR_BIT = 0;

  localparam int ST_UNDERFLOW = 31;
  localparam int ST_FULL      = 30;
  localparam int ST_EMPTY     = 29;
  localparam int ST_COUNT_LSB = 24;
  localparam int ST_PACK_LSB  = 16;
  localparam int ST_WORDS_LSB = 0;

  // Lane n holds the n-th byte of a word on the serial stream (MSB first).
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  function automatic logic [31:0] place_byte(input logic [1:0] lane, input logic [7:0] b);
    logic [31:0] w;
    w = '0;
    case (lane)
      2'd0:    w[LANE0_LSB +: 8] = b;
      2'd1:    w[LANE1_LSB +: 8] = b;
      2'd2:    w[LANE2_LSB +: 8] = b;
      default: w[LANE3_LSB +: 8] = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/npu_result_reader_if.sv
// NPU result byte stream plus the chipselect-qualified Avalon-style slave bus.
interface npu_result_reader_if;

  logic [7:0]  result_data;
  logic        result_valid;
  logic        result_last;
  logic        result_ready;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  result_data, result_valid, result_last,
    input  chipselect, read, write, address, writedata,
    output result_ready, readdata
  );

  modport master (
    output result_data, result_valid, result_last,
    output chipselect, read, write, address, writedata,
    input  result_ready, readdata
  );

endinterface

// File: rtl/npu_word_fifo.sv
// Synchronous word FIFO with clear; head is the combinational read of the oldest entry.
module npu_word_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/npu_result_reader.sv
// Packs the NPU serial result bytes into 32-bit words, buffers them, and serves them on the slave bus.
module npu_result_reader
  import npu_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  parameter int WCNT_W     = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  npu_result_reader_if.slave   bus
);

  logic              ready_en;
  logic              ready;
  logic              rd_req;
  logic              wr_req;
  logic              clr;
  logic              accept;
  logic              push;
  logic              pop_req;
  logic              pop;
  logic [1:0]        pack_cnt;
  logic [31:0]       pack_word;
  logic [31:0]       merged;
  logic [31:0]       head;
  logic [31:0]       status;
  logic [31:0]       rd_mux;
  logic [31:0]       readdata_q;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [WCNT_W-1:0] words_pushed;
  logic              underflow;
  logic              unused_wd;

  assign unused_wd = ^bus.writedata[31:1];

  // ready_en keeps result_ready low through reset and the edge that releases it.
  assign ready            = ready_en && !full;
  assign bus.result_ready = ready;

  assign rd_req  = bus.chipselect && bus.read && !bus.write;
  assign wr_req  = bus.chipselect && bus.write;
  assign clr     = wr_req && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_CLEAR_BIT];
  assign accept  = bus.result_valid && ready && !clr;
  assign merged  = pack_word | place_byte(pack_cnt, bus.result_data);
  assign push    = accept && ((pack_cnt == 2'd3) || bus.result_last);
  assign pop_req = rd_req && (bus.address == ADDR_POP);
  assign pop     = pop_req && !empty;

  npu_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (clr),
    .push      (push),
    .push_data (merged),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en     <= 1'b0;
      pack_cnt     <= '0;
      pack_word    <= '0;
      words_pushed <= '0;
      underflow    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (clr) begin
        pack_cnt     <= '0;
        pack_word    <= '0;
        words_pushed <= '0;
        underflow    <= 1'b0;
      end else begin
        if (push) begin
          pack_cnt     <= '0;
          pack_word    <= '0;
          words_pushed <= words_pushed + 1'b1;
        end else if (accept) begin
          pack_cnt  <= pack_cnt + 2'd1;
          pack_word <= merged;
        end
        if (pop_req && empty) underflow <= 1'b1;
      end
    end
  end

  always_comb begin
    status                            = '0;
    status[ST_UNDERFLOW]              = underflow;
    status[ST_FULL]                   = full;
    status[ST_EMPTY]                  = empty;
    status[ST_COUNT_LSB +: CNT_W]     = count;
    status[ST_PACK_LSB +: 2]          = pack_cnt;
    status[ST_WORDS_LSB +: WCNT_W]    = words_pushed;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_POP:    rd_mux = empty ? 32'h0 : head;
      ADDR_STATUS: rd_mux = status;
      default:     rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      readdata_q <= '0;
    else if (rd_req) readdata_q <= rd_mux;
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_npu_result_reader.sv
// Table-driven and randomized bench for npu_result_reader against a queue-based model.
module tb_npu_result_reader;

  localparam int DEPTH = 16;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        chk;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npu_result_reader_if bus();

  npu_result_reader #(.FIFO_DEPTH(DEPTH), .CNT_W(5), .WCNT_W(14)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  string ctx = "init";

  logic [31:0] mq[$];
  logic [7:0]  bq[$];
  int          words = 0;
  bit          uf = 1'b0;
  logic [31:0] rd_model = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %08h expected %08h", ctx, name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] q[$]);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < q.size(); i++) w |= 32'(q[i]) << (24 - 8 * i);
    return w;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int c;
    c = mq.size();
    s = 32'(c) << 24;
    if (uf) s |= 32'h8000_0000;
    if (c == DEPTH) s |= 32'h4000_0000;
    if (c == 0) s |= 32'h2000_0000;
    s |= 32'(bq.size()) << 16;
    s |= 32'(words);
    return s;
  endfunction

  function automatic vec_t idle();
    vec_t x;
    x = '{default: '0};
    return x;
  endfunction

  function automatic vec_t bv(input logic [7:0] d, input logic l);
    vec_t x;
    x = idle();
    x.v = 1'b1; x.d = d; x.l = l;
    return x;
  endfunction

  function automatic vec_t rv(input logic [1:0] a);
    vec_t x;
    x = idle();
    x.cs = 1'b1; x.rd = 1'b1; x.a = a;
    return x;
  endfunction

  function automatic vec_t rvx(input logic [1:0] a, input logic [31:0] e);
    vec_t x;
    x = rv(a);
    x.exp = e; x.chk = 1'b1;
    return x;
  endfunction

  function automatic vec_t wv(input logic [1:0] a, input logic [31:0] wd);
    vec_t x;
    x = idle();
    x.cs = 1'b1; x.wr = 1'b1; x.a = a; x.wd = wd;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    bus.result_valid = x.v;  bus.result_data = x.d; bus.result_last = x.l;
    bus.chipselect   = x.cs; bus.read = x.rd;       bus.write = x.wr;
    bus.address      = x.a;  bus.writedata = x.wd;
  endtask

  // One bus/stream cycle: model the edge from the spec rules, then compare.
  task automatic step(input vec_t x);
    bit do_rd, do_clr, exp_rdy;
    logic [31:0] tmp;
    @(negedge clk);
    drive(x);
    exp_rdy = (mq.size() < DEPTH);
    #1 chk("ready", 32'(bus.result_ready), 32'(exp_rdy));
    do_rd  = x.cs && x.rd && !x.wr;
    do_clr = x.cs && x.wr && (x.a == 2'd3) && x.wd[0];
    if (do_rd) begin
      case (x.a)
        2'd0:    rd_model = (mq.size() > 0) ? mq[0] : 32'h0;
        2'd1:    rd_model = model_status();
        default: rd_model = 32'h0;
      endcase
    end
    if (do_clr) begin
      mq.delete(); bq.delete(); words = 0; uf = 1'b0;
    end else begin
      if (do_rd && x.a == 2'd0) begin
        if (mq.size() > 0) tmp = mq.pop_front();
        else uf = 1'b1;
      end
      if (x.v && exp_rdy) begin
        bq.push_back(x.d);
        if (bq.size() == 4 || x.l) begin
          mq.push_back(pack(bq));
          bq.delete();
          words = (words + 1) % 16384;
        end
      end
    end
    @(posedge clk);
    #1 chk("readdata", bus.readdata, rd_model);
    if (x.chk) chk("expected", bus.readdata, x.exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(idle());
    rst_n = 1'b0;
    #1;
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_ready", 32'(bus.result_ready), 32'h0);
    mq.delete(); bq.delete(); words = 0; uf = 1'b0; rd_model = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", 32'(bus.result_ready), 32'h1);
  endtask

  vec_t tbl[16];
  vec_t x;

  initial begin
    drive(idle());

    tbl[0]  = bv(8'h01, 1'b0);
    tbl[1]  = bv(8'h03, 1'b0);
    tbl[2]  = bv(8'h07, 1'b0);
    tbl[3]  = bv(8'h0F, 1'b0);
    tbl[4]  = rvx(2'd0, 32'h0103070F);
    tbl[5]  = rvx(2'd1, 32'h2000_0001);
    tbl[6]  = bv(8'hAA, 1'b0);
    tbl[7]  = bv(8'hBB, 1'b1);
    tbl[8]  = rvx(2'd1, 32'h0100_0002);
    tbl[9]  = rvx(2'd0, 32'hAABB0000);
    tbl[10] = rvx(2'd0, 32'h0);
    tbl[11] = rvx(2'd1, 32'hA000_0002);
    tbl[12] = wv(2'd3, 32'h1);
    tbl[13] = rvx(2'd1, 32'h2000_0000);
    tbl[14] = rvx(2'd2, 32'h0);
    tbl[15] = rvx(2'd3, 32'h0);

    ctx = "table";
    do_reset();
    for (int i = 0; i < 16; i++) step(tbl[i]);

    ctx = "full";
    do_reset();
    for (int i = 0; i < 4 * DEPTH; i++) step(bv(8'($urandom), 1'b0));
    chk("full_ready", 32'(bus.result_ready), 32'h0);
    step(bv(8'h5A, 1'b0));
    step(rvx(2'd1, 32'h5000_0010));
    step(rv(2'd0));
    chk("ready_back", 32'(bus.result_ready), 32'h1);
    for (int i = 0; i < 4; i++) step(bv(8'(8'hC0 + i), 1'b0));
    chk("refull_ready", 32'(bus.result_ready), 32'h0);
    step(rvx(2'd1, 32'h5000_0011));

    ctx = "pushpop";
    do_reset();
    step(bv(8'h11, 1'b0)); step(bv(8'h22, 1'b0)); step(bv(8'h33, 1'b0)); step(bv(8'h44, 1'b0));
    step(bv(8'h55, 1'b0)); step(bv(8'h66, 1'b0)); step(bv(8'h77, 1'b0));
    x = bv(8'h88, 1'b0);
    x.cs = 1'b1; x.rd = 1'b1; x.a = 2'd0; x.exp = 32'h11223344; x.chk = 1'b1;
    step(x);
    step(rvx(2'd1, 32'h0100_0002));
    step(rvx(2'd0, 32'h55667788));
    step(rvx(2'd1, 32'h2000_0002));

    ctx = "stream";
    for (int i = 0; i < 8; i++) step(bv(8'($urandom), 1'b0));
    for (int i = 0; i < 64; i++) begin
      x = bv(8'($urandom), 1'b0);
      if (i % 4 == 3) begin x.cs = 1'b1; x.rd = 1'b1; x.a = 2'd0; end
      step(x);
    end
    step(rv(2'd1));
    chk("stream_count", (bus.readdata >> 24) & 32'h1F, 32'd2);

    ctx = "midrst";
    for (int i = 0; i < 14; i++) step(bv(8'($urandom), 1'b0));
    step(rv(2'd1));
    do_reset();
    step(rvx(2'd1, 32'h2000_0000));
    step(bv(8'hDE, 1'b0)); step(bv(8'hAD, 1'b0)); step(bv(8'hBE, 1'b0)); step(bv(8'hEF, 1'b0));
    step(rvx(2'd0, 32'hDEADBEEF));

    ctx = "random";
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int op;
      int rd_pct;
      rd_pct = ((i / 150) % 2 == 0) ? 15 : 45;
      x = idle();
      x.v  = ($urandom % 4) != 0;
      x.d  = 8'($urandom);
      x.l  = ($urandom % 8) == 0;
      x.cs = ($urandom % 8) != 0;
      op = int'($urandom % 100);
      if (op < rd_pct) begin
        x.rd = 1'b1;
        x.a  = (($urandom % 3) == 0) ? 2'($urandom) : 2'd0;
        x.wr = ($urandom % 16) == 0;
      end else if (op < rd_pct + 4) begin
        x.wr = 1'b1;
        x.a  = 2'($urandom);
        x.wd = $urandom;
        x.wd[0] = ($urandom % 3) == 0;
      end
      step(x);
    end
    step(rv(2'd1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
